// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared widths, control-bundle layout and bubble encoding for the
//            pipeline stage register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int c_DEFAULT_DATA_W = 96;
    localparam int c_DEFAULT_CTRL_W = 24;

    // A bubble is an all-zero control bundle; slots replicate this bit.
    localparam logic c_BUBBLE_BIT = 1'b0;

    // Bit positions of the control bundle, LSB last.
    typedef struct packed {
        logic [15:0] rsvd;
        logic [2:0]  wb_sel;
        logic [2:0]  alu_op;
        logic        mem_wr;
        logic        reg_wr;
    } ctrl_fields_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One storage entry (valid, ctrl, payload). The clear input
//            dominates load; reset dominates both.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W     = c_DEFAULT_DATA_W,
    parameter int CTRL_W     = c_DEFAULT_CTRL_W,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{c_BUBBLE_BIT}};
            r_data  <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRL_W{c_BUBBLE_BIT}};
            // Payload is otherwise left stale; it is don't-care while invalid.
            if (CLEAR_DATA != 0) begin
                r_data <= '0;
            end
        end else if (load) begin
            r_valid <= 1'b1;
            r_ctrl  <= d_ctrl;
            r_data  <= d_data;
        end
    end

    assign valid = r_valid;
    assign ctrl  = r_ctrl;
    assign data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with flush and stall.
//            Define PIPE_STAGE_SKID_EN for a two-entry skid buffer whose
//            in_ready is fully registered; otherwise a single entry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = c_DEFAULT_DATA_W,
    parameter int CTRL_W     = c_DEFAULT_CTRL_W,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall,
    output logic [1:0]        occupancy
);

    logic              w_run;
    logic              w_take_in;
    logic              w_take_out;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_load;
    logic              w_main_clear;

    // Reset, flush and stall all block both handshakes for the cycle.
    assign w_run      = reset && !flush && !stall;
    assign out_valid  = w_main_valid && w_run;
    assign out_ctrl   = out_valid ? w_main_ctrl : {CTRL_W{c_BUBBLE_BIT}};
    assign out_data   = w_main_data;
    assign w_take_in  = in_valid && in_ready;
    assign w_take_out = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_from_skid;
    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_d_data;

    // Depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready = w_run && !w_skid_valid;

    always_comb begin
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_take_out) begin
            if (w_skid_valid) begin
                w_main_load      = 1'b1;
                w_main_from_skid = 1'b1;
                w_skid_clear     = 1'b1;
            end else if (w_take_in) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else if (w_take_in) begin
            if (w_main_valid) begin
                w_skid_load = 1'b1;
            end else begin
                w_main_load = 1'b1;
            end
        end
    end

    assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (w_main_load),
        .clear  (w_main_clear),
        .d_ctrl (w_main_d_ctrl),
        .d_data (w_main_d_data),
        .valid  (w_main_valid),
        .ctrl   (w_main_ctrl),
        .data   (w_main_data)
    );

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (w_skid_load),
        .clear  (w_skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (w_skid_valid),
        .ctrl   (w_skid_ctrl),
        .data   (w_skid_data)
    );

    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`else

    assign in_ready = w_run && (!w_main_valid || out_ready);

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
        end else if (w_take_in) begin
            w_main_load = 1'b1;
        end else if (w_take_out) begin
            w_main_clear = 1'b1;
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (w_main_load),
        .clear  (w_main_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (w_main_valid),
        .ctrl   (w_main_ctrl),
        .data   (w_main_data)
    );

    assign occupancy = {1'b0, w_main_valid};

`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg against a queue model;
//            honours PIPE_STAGE_SKID_EN to select the expected depth.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 24;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              stall;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];

    pipe_stage_reg #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .stall     (stall),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a FIFO of capacity DEPTH; outputs follow from its size and the inputs.
    function automatic logic m_out_valid();
        return reset && !flush && !stall && (q.size() > 0);
    endfunction

    function automatic logic m_in_ready();
        if (!reset || flush || stall) return 1'b0;
        if (q.size() < DEPTH) return 1'b1;
        return (DEPTH == 1) && out_ready;
    endfunction

    always @(posedge clk) begin
        logic ti, to;
        ti = in_valid && m_in_ready();
        to = m_out_valid() && out_ready;
        if (!reset || flush) begin
            q.delete();
        end else begin
            if (to) void'(q.pop_front());
            if (ti) q.push_back('{c: in_ctrl, d: in_data});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic ev;
            ev = m_out_valid();
            check("in_ready", in_ready, m_in_ready());
            check("out_valid", out_valid, ev);
            check("out_ctrl", out_ctrl, ev ? q[0].c : '0);
            if (ev) check("out_data", out_data, q[0].d);
            check("occupancy", occupancy, q.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            in_valid = 1'b1;
            in_data  = DATA_W'(base + k);
            in_ctrl  = 24'h00FFFF;
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; stall = 1'b0;

        // Reset state
        tick();
        cmp_en = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_occ", occupancy, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);

        // Streaming 1..8
        tick();
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            in_valid = (i <= 8);
            in_data  = DATA_W'(i);
            in_ctrl  = CTRL_W'(i);
            #2;
            if (i >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, i - 1);
                check("stream_occ", occupancy, 1);
            end
        end
        tick();
        in_valid = 1'b0;
        #2 check("stream_drain_occ", occupancy, 0);

        // Backpressure
`ifdef PIPE_STAGE_SKID_EN
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 3; in_ctrl = 3;
        #2 check("bp_ready_a", in_ready, 1);
        tick();
        in_data = 4; in_ctrl = 4;
        #2 check("bp_ready_b", in_ready, 1);
        tick();
        in_data = 99; in_ctrl = 99;
        #2;
        check("bp_ready_full", in_ready, 0);
        check("bp_occ_full", occupancy, 2);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #2 check("bp_first", out_data, 3);
        tick();
        #2;
        check("bp_second", out_data, 4);
        check("bp_occ_one", occupancy, 1);
        tick();
        #2 check("bp_occ_empty", occupancy, 0);
`else
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 3; in_ctrl = 3;
        #2 check("bp_ready_a", in_ready, 1);
        tick();
        in_data = 4; in_ctrl = 4;
        #2;
        check("bp_ready_full", in_ready, 0);
        check("bp_occ_full", occupancy, 1);
        out_ready = 1'b1;
        #1 check("bp_ready_comb", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #2;
        check("bp_second", out_data, 4);
        check("bp_occ_one", occupancy, 1);
        tick();
        #2 check("bp_occ_empty", occupancy, 0);
`endif

        // Flush
        fill(20);
        tick();
        in_valid = 1'b1; flush = 1'b1;
        #2;
        check("fl_in_ready", in_ready, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_occ_before", occupancy, DEPTH);
        tick();
        flush = 1'b0; in_data = 9; in_ctrl = 9; out_ready = 1'b1;
        #2;
        check("fl_occ_after", occupancy, 0);
        check("fl_out_valid_after", out_valid, 0);
        check("fl_out_ctrl_after", out_ctrl, 0);
        tick();
        in_valid = 1'b0;
        #2;
        check("fl_next_valid", out_valid, 1);
        check("fl_next_data", out_data, 9);
        tick();

        // Stall with entry 5 held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 5; in_ctrl = 5;
        tick();
        in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2;
            check("st_out_valid", out_valid, 0);
            check("st_occ", occupancy, 1);
            tick();
            if (s == 2) stall = 1'b0;
        end
        #2;
        check("st_release_valid", out_valid, 1);
        check("st_release_data", out_data, 5);
        tick();
        #2;
        check("st_once_valid", out_valid, 0);
        check("st_once_occ", occupancy, 0);

        // Reset mid-stream
        fill(30);
        tick();
        in_valid = 1'b1; reset = 1'b0;
        #2 check("rm_in_ready", in_ready, 0);
        tick();
        #2;
        check("rm_out_valid", out_valid, 0);
        check("rm_out_ctrl", out_ctrl, 0);
        check("rm_out_data", out_data, 0);
        check("rm_occ", occupancy, 0);
        check("rm_in_ready_hold", in_ready, 0);
        tick();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            tick();
            reset     = ($urandom_range(0, 59) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            stall     = ($urandom_range(0, 9) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = CTRL_W'($urandom);
        end
        tick();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        #2 check("final_occ", occupancy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
